// File: rtl/lcd_scan_if.sv
// Scan-out bus between the LCD timing master and the pixel source / panel pins.
interface lcd_scan_if;
  logic        EN;
  logic        on;
  logic [13:0] hcnt;
  logic [23:0] vcnt;
  logic        HSYNC;
  logic        VSYNC;
  logic        DE;
  logic [23:0] RGB;
  logic        frame_start;

  modport master (
    input  EN, on,
    output hcnt, vcnt, HSYNC, VSYNC, DE, RGB, frame_start
  );

  modport slave (
    output EN, on,
    input  hcnt, vcnt, HSYNC, VSYNC, DE, RGB, frame_start
  );
endinterface

// File: rtl/lcd_scan_driver.sv
// LCD scan-timing master: sync/blanking, pixel read address, 1-bit pixel to RGB.
// Addresses one clock after the counters, syncs/DE/RGB two clocks after; no backpressure, one pixel per clock.
module lcd_scan_driver #(
  parameter int          HSIZE     = 480,
  parameter int          VSIZE     = 272,
  parameter int          HPW       = 41,
  parameter int          HBP       = 2,
  parameter int          HFP       = 2,
  parameter int          VPW       = 10,
  parameter int          VBP       = 2,
  parameter int          VFP       = 2,
  parameter logic [23:0] ON_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] OFF_COLOR = 24'h000000
) (
  input  logic       CLK,
  input  logic       RESET,
  lcd_scan_if.master bus
);

  // Both totals must fit the 11-bit position counters (<= 2047).
  localparam int HTOTAL = HPW + HBP + HSIZE + HFP;
  localparam int VTOTAL = VPW + VBP + VSIZE + VFP;

  localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);
  localparam logic [10:0] H_SYNC = 11'(HPW);
  localparam logic [10:0] V_SYNC = 11'(VPW);
  localparam logic [10:0] H_ACT0 = 11'(HPW + HBP);
  localparam logic [10:0] H_ACT1 = 11'(HPW + HBP + HSIZE);
  localparam logic [10:0] V_ACT0 = 11'(VPW + VBP);
  localparam logic [10:0] V_ACT1 = 11'(VPW + VBP + VSIZE);

  logic [10:0] h_pos_q, h_pos_d;
  logic [10:0] v_pos_q, v_pos_d;
  logic [23:0] pix_q, pix_d;
  logic [13:0] hcnt_q, hcnt_d;
  logic [23:0] vcnt_q, vcnt_d;
  logic        de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
  logic        de2_q, de2_d, hsync_q, hsync_d, vsync_q, vsync_d, fs2_q, fs2_d;
  logic        active;

  always_comb begin
    h_pos_d = h_pos_q;
    v_pos_d = v_pos_q;
    pix_d   = pix_q;

    active = bus.EN
          && (h_pos_q >= H_ACT0) && (h_pos_q < H_ACT1)
          && (v_pos_q >= V_ACT0) && (v_pos_q < V_ACT1);

    if (!bus.EN) begin
      h_pos_d = '0;
      v_pos_d = '0;
      pix_d   = '0;
    end else begin
      if (h_pos_q == H_LAST) begin
        h_pos_d = '0;
        v_pos_d = (v_pos_q == V_LAST) ? 11'd0 : v_pos_q + 11'd1;
      end else begin
        h_pos_d = h_pos_q + 11'd1;
      end
      // The linear index replaces row*HSIZE+col; it is zero again when (0,0) comes round.
      if ((h_pos_q == H_LAST) && (v_pos_q == V_LAST)) begin
        pix_d = '0;
      end else if (active) begin
        pix_d = pix_q + 24'd1;
      end
    end

    hcnt_d = active ? 14'(h_pos_q - H_ACT0) : 14'd0;
    vcnt_d = active ? pix_q : 24'd0;
    de1_d  = active;
    hs1_d  = bus.EN && (h_pos_q < H_SYNC);
    vs1_d  = bus.EN && (v_pos_q < V_SYNC);
    fs1_d  = bus.EN && (h_pos_q == 11'd0) && (v_pos_q == 11'd0);

    // Second stage lines up with the pixel source's registered `on`.
    de2_d   = de1_q;
    hsync_d = ~hs1_q;
    vsync_d = ~vs1_q;
    fs2_d   = fs1_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      h_pos_q <= '0;
      v_pos_q <= '0;
      pix_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      de2_q   <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs2_q   <= 1'b0;
    end else begin
      h_pos_q <= h_pos_d;
      v_pos_q <= v_pos_d;
      pix_q   <= pix_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      de1_q   <= de1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= fs1_d;
      de2_q   <= de2_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs2_q   <= fs2_d;
    end
  end

  assign bus.hcnt        = hcnt_q;
  assign bus.vcnt        = vcnt_q;
  assign bus.DE          = de2_q;
  assign bus.HSYNC       = hsync_q;
  assign bus.VSYNC       = vsync_q;
  assign bus.frame_start = fs2_q;
  assign bus.RGB         = de2_q ? (bus.on ? ON_COLOR : OFF_COLOR) : 24'd0;

endmodule

// File: tb/tb_lcd_scan_driver.sv
// Bench for lcd_scan_driver at reduced geometry against a position-index reference model.
module tb_lcd_scan_driver;
  localparam int HS  = 8;
  localparam int VS  = 4;
  localparam int HPW = 2;
  localparam int HBP = 1;
  localparam int HFP = 1;
  localparam int VPW = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;
  localparam int HT  = HPW + HBP + HS + HFP;
  localparam int VT  = VPW + VBP + VS + VFP;
  localparam int P   = HT * VT;

  logic CLK = 1'b0;
  logic RESET;
  lcd_scan_if bus();

  lcd_scan_driver #(
    .HSIZE(HS), .VSIZE(VS), .HPW(HPW), .HBP(HBP), .HFP(HFP),
    .VPW(VPW), .VBP(VBP), .VFP(VFP),
    .ON_COLOR(24'hFFFFFF), .OFF_COLOR(24'h000000)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Pixel-source stub: registers `on` from the read address.
  initial bus.on = 1'b0;
  always @(posedge CLK) bus.on <= (bus.hcnt == 14'd3) && (bus.vcnt < 24'd16);

  int n_assert = 0;
  int n_fail   = 0;
  int s        = 0;
  int hist1    = -1;
  int hist2    = -1;
  int cyc      = 0;
  int last_fs  = -1;
  int de_cnt   = 0;
  int vs_cnt   = 0;
  int hs_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit act(input int k);
    int h, v;
    h = k % HT;
    v = k / HT;
    return (h >= HPW + HBP) && (h < HPW + HBP + HS) && (v >= VPW + VBP) && (v < VPW + VBP + VS);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hcnt"},  32'(bus.hcnt), 32'd0);
    chk({tag, "_vcnt"},  32'(bus.vcnt), 32'd0);
    chk({tag, "_hsync"}, 32'(bus.HSYNC), 32'd1);
    chk({tag, "_vsync"}, 32'(bus.VSYNC), 32'd1);
    chk({tag, "_de"},    32'(bus.DE), 32'd0);
    chk({tag, "_fs"},    32'(bus.frame_start), 32'd0);
    chk({tag, "_rgb"},   32'(bus.RGB), 32'd0);
  endtask

  // hist1 / hist2: scan position (-1 = idle) whose stage-1 / stage-2 outputs are now visible.
  task automatic check_outputs();
    logic [31:0] e_hc, e_vc, e_rgb;
    bit e_de, e_hs, e_vs, e_fs;
    int col, row;
    e_hc = 0;
    e_vc = 0;
    if (hist1 >= 0 && act(hist1)) begin
      col  = hist1 % HT - (HPW + HBP);
      row  = hist1 / HT - (VPW + VBP);
      e_hc = 32'(col);
      e_vc = 32'(row * HS + col);
    end
    e_de  = (hist2 >= 0) && act(hist2);
    e_hs  = !((hist2 >= 0) && (hist2 % HT < HPW));
    e_vs  = !((hist2 >= 0) && (hist2 / HT < VPW));
    e_fs  = (hist2 == 0);
    e_rgb = 0;
    if (e_de) begin
      col = hist2 % HT - (HPW + HBP);
      row = hist2 / HT - (VPW + VBP);
      if (col == 3 && row < 2) e_rgb = 32'hFFFFFF;
    end
    chk("hcnt",  32'(bus.hcnt), e_hc);
    chk("vcnt",  32'(bus.vcnt), e_vc);
    chk("de",    32'(bus.DE), 32'(e_de));
    chk("hsync", 32'(bus.HSYNC), 32'(e_hs));
    chk("vsync", 32'(bus.VSYNC), 32'(e_vs));
    chk("fs",    32'(bus.frame_start), 32'(e_fs));
    chk("rgb",   32'(bus.RGB), e_rgb);

    // Whole-frame totals measured between consecutive frame starts.
    if (e_fs) begin
      if (last_fs >= 0) begin
        chk("fs_period",  32'(cyc - last_fs), 32'(P));
        chk("de_per_frm", 32'(de_cnt), 32'(HS * VS));
        chk("vs_low_frm", 32'(vs_cnt), 32'(VPW * HT));
        chk("hs_low_frm", 32'(hs_cnt), 32'(HPW * VT));
      end
      last_fs = cyc;
      de_cnt  = 0;
      vs_cnt  = 0;
      hs_cnt  = 0;
    end
    de_cnt += int'(bus.DE === 1'b1);
    vs_cnt += int'(bus.VSYNC === 1'b0);
    hs_cnt += int'(bus.HSYNC === 1'b0);
  endtask

  // Called just after a falling edge with inputs already set for the next rising edge.
  task automatic step();
    int idx0;
    idx0 = bus.EN ? s : -1;
    @(posedge CLK);
    if (RESET) begin
      s     = bus.EN ? (s + 1) % P : 0;
      hist2 = hist1;
      hist1 = idx0;
    end
    @(negedge CLK);
    cyc++;
    check_outputs();
  endtask

  task automatic model_reset();
    s       = 0;
    hist1   = -1;
    hist2   = -1;
    last_fs = -1;
  endtask

  initial begin
    int n;
    RESET  = 1'b1;
    bus.EN = 1'b0;
    #1 RESET = 1'b0;
    #1 check_reset_vals("rst0");
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();

    // Three-plus frames of continuous scanning.
    bus.EN = 1'b1;
    for (int i = 0; i < 3 * P + 4; i++) step();

    // Drop EN for 5 clocks in the middle of the first active line.
    for (int i = 0; i < P + 1; i++) begin
      if (s == (VPW + VBP) * HT + HPW + HBP + 3) break;
      step();
    end
    bus.EN  = 1'b0;
    last_fs = -1;
    for (int i = 0; i < 5; i++) step();
    bus.EN = 1'b1;
    for (int i = 0; i < P + 10; i++) step();

    // Random EN drops of random length.
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(150, 20);
      for (int i = 0; i < n; i++) step();
      bus.EN  = 1'b0;
      last_fs = -1;
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) step();
      bus.EN = 1'b1;
    end
    for (int i = 0; i < P + 5; i++) step();

    // Asynchronous reset between edges at a random point in the frame.
    n = $urandom_range(200, 30);
    for (int i = 0; i < n; i++) step();
    #2 RESET = 1'b0;
    #1 check_reset_vals("rst_async");
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("rst_held");
    RESET  = 1'b1;
    bus.EN = 1'b1;
    for (int i = 0; i < 2 * P + 5; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_scan_driver.md
# lcd_scan_driver

Scan-timing master for the 480x272 RGB LCD path: generates sync/blanking timing and the pixel read addresses (`hcnt`, `vcnt`) consumed by the pixel-source block, then converts the returned 1-bit `on` pixel into 24-bit RGB with DE and syncs aligned. It is the reading end of the frame-buffer interface. The cursor/bitmap block writes the bitmap; this block scans it out at one pixel per clock.

## Interface
- `HSIZE`, 480: active pixels per line.
- `VSIZE`, 272: active lines per frame.
- `HPW` / `HBP` / `HFP`, 41 / 2 / 2: horizontal sync width, back porch and front porch, in clocks.
- `VPW` / `VBP` / `VFP`, 10 / 2 / 2: vertical sync width, back porch and front porch, in lines.
- `ON_COLOR`, 24'hFFFFFF: RGB driven for a lit pixel.
- `OFF_COLOR`, 24'h000000: RGB driven for an unlit active pixel.

Ports:
- `CLK`  in  1: pixel clock.
- `RESET`  in  1: reset, asynchronous, active-low.
- `EN`  in  1: scan enable.
- `on`  in  1: pixel value from the pixel source, valid one clock after `hcnt`/`vcnt`.
- `hcnt`  out  14: active column, 0..HSIZE-1.
- `vcnt`  out  24: linear active pixel index, row*HSIZE+col.
- `HSYNC`  out  1: horizontal sync, active-low.
- `VSYNC`  out  1: vertical sync, active-low.
- `DE`  out  1: data enable, high on active pixels.
- `RGB`  out  24: pixel colour.
- `frame_start`  out  1: one-clock pulse at the start of each frame.

## Operation
- HTOTAL = HPW+HBP+HSIZE+HFP = 525. VTOTAL = VPW+VBP+VSIZE+VFP = 286. Both are computed as localparams.
- Internal counters:
  - `h_pos` runs 0..HTOTAL-1 and wraps to 0.
  - `v_pos` increments only when `h_pos` wraps, and itself wraps VTOTAL-1 -> 0.
  - Each counter is 11 bits; HTOTAL and VTOTAL must each be ≤ 2047.
- Line order is sync, back porch, active, front porch. Frame order is the same, in lines.
- Regions:
  - hsync_raw = h_pos < HPW.
  - vsync_raw = v_pos < VPW (whole lines).
  - active = h_pos in [HPW+HBP, HPW+HBP+HSIZE) AND v_pos in [VPW+VBP, VPW+VBP+VSIZE).
- `vcnt` comes from an incrementing pixel-index counter; no multiplier is used.
  - The counter clears to 0 at (h_pos,v_pos)=(0,0).
  - It increments after each active pixel.
- During blanking, `hcnt` = 0 and `vcnt` = 0. The downstream pixel read is don't-care because DE gates it.
- `RGB` = DE ? (on ? ON_COLOR : OFF_COLOR) : 0. This is combinational from registered `DE` and `on`.
- `EN` low: counters are synchronously held at (0,0) and the pixel index at 0.
  - The pipeline keeps shifting idle values: `DE`=0, `HSYNC`=`VSYNC`=1, `frame_start`=0, `hcnt`=`vcnt`=0.
- `EN` rising: scanning restarts at (0,0). The first `frame_start` follows with the standard latency.
- `EN` falling mid-frame: the frame is abandoned, with no partial completion. Outputs reach idle values within 2 clocks.
- `RESET` low, at any time including mid-line: all state clears immediately. Reset values:
  - `h_pos` = `v_pos` = 0 and pixel index = 0.
  - `hcnt` = 0, `vcnt` = 0.
  - `HSYNC` = 1, `VSYNC` = 1.
  - `DE` = 0, `frame_start` = 0, `RGB` = 0.

## Timing
- Stage 0 (cycle n): counters at (h,v).
- Stage 1 (cycle n+1): `hcnt`/`vcnt` for (h,v) are visible. They are registered, with no combinational path from counters to outputs.
- Stage 2 (cycle n+2):
  - `DE`, `HSYNC`, `VSYNC` and `frame_start` for (h,v) are visible (registered, two-stage delay).
  - The pixel source has registered `on` at the end of n+1, so `RGB` is aligned with `DE`.
- `frame_start` is high in the stage-2 cycle of (0,0). It coincides with the first low cycle of `VSYNC` and of `HSYNC`.
- Per line: `HSYNC` low for exactly HPW clocks; `DE` high for exactly HSIZE consecutive clocks, starting HPW+HBP clocks after HSYNC falls.
- Per frame:
  - `VSYNC` low for VPW*HTOTAL clocks.
  - HSIZE*VSIZE `DE` cycles.
  - Period of HTOTAL*VTOTAL clocks (150150 at defaults).
- While `DE` is high, `vcnt` steps by exactly 1 per clock, without gaps across lines: the last pixel of row r is followed by the first of row r+1.
- `vcnt` goes from HSIZE*VSIZE-1 back to 0 at the next frame.

## Test plan
Small parameters for speed: HSIZE=8, VSIZE=4, HPW=2, HBP=1, HFP=1, VPW=1, VBP=1, VFP=1. This gives HTOTAL=12 and VTOTAL=7.

1. Reset release with `EN`=1, run 3 frames -> `frame_start` pulses exactly every 84 clocks; `VSYNC` low for 12 clocks per frame; `HSYNC` low for 2 of every 12 clocks.
2. Same run, count `DE` -> 32 high cycles per frame, in 4 runs of 8. The first DE of each line comes 3 clocks after the HSYNC falling edge.
3. Sample `hcnt`/`vcnt` one clock before each `DE` cycle -> `hcnt` sequence 0..7 per line; `vcnt` 0..31 contiguous per frame, then 0 again.
4. Pixel-source stub registering `on` = (hcnt==3 && vcnt<16) -> `RGB`=FFFFFF on the 4th DE pixel of lines 0-1 only. All other DE pixels are 000000; blanking is 0.
5. Drop `EN` for 5 clocks mid-active-line -> within 2 clocks `DE`=0, `HSYNC`=`VSYNC`=1, `hcnt`=`vcnt`=0. After re-assert, `frame_start` occurs 2 clocks later and `vcnt` restarts at 0.
6. Assert `RESET` low asynchronously mid-frame, between clock edges -> all outputs take reset values immediately. After release, timing matches scenario 1 from (0,0).
